// File: rtl/sram_pkg.sv
// sram_pkg: shared defaults and init FSM state type for the dual-port SRAM with clear sweep
package sram_pkg;
   localparam int SRAM_DEFAULT_DEPTH = 512;
   localparam int SRAM_DEFAULT_WIDTH = 64;
   typedef enum logic {INIT, READY} sram_init_state_t;
endpackage

// File: rtl/sram_dp_core.sv
// sram_dp_core: raw 1W1R word array with byte write mask and 1-cycle registered read
// Ports: clk; write port we/waddr/wdata/wbe; read port re/raddr -> rdata (next cycle, pre-write on collision).
// This is the single substitution point for a PDK dual-port macro.
module sram_dp_core import sram_pkg::*; #(
   parameter int DEPTH = SRAM_DEFAULT_DEPTH,
   parameter int WIDTH = SRAM_DEFAULT_WIDTH,
   localparam int AW = $clog2(DEPTH),
   localparam int BW = WIDTH / 8
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [BW-1:0]    wbe,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      for (int i = 0; i < BW; i++) if (we && wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/sram_dp_init.sv
// sram_dp_init: dual-port SRAM that zeroes itself after reset, then serves byte-masked writes and latency-1 reads
// Ports: clk, rst (sync, active-high, restarts sweep); we/waddr/wdata/wbe write; re/raddr read;
//        rdata/rvalid read result strobe (rdata holds while rvalid=0); init_done high once the sweep finished.
// Macro SRAM_DP_BYPASS_EN: same-address read-during-write returns the post-write word (default: pre-write word).
module sram_dp_init import sram_pkg::*; #(
   parameter int DEPTH = SRAM_DEFAULT_DEPTH,
   parameter int WIDTH = SRAM_DEFAULT_WIDTH,
   localparam int AW = $clog2(DEPTH),
   localparam int BW = WIDTH / 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [BW-1:0]    wbe,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   output logic             init_done
);
   sram_init_state_t state;
   logic [AW-1:0] cnt;
   logic [WIDTH-1:0] q, rd, hold;
   logic ready, mwe, mre;
   assign ready = state == READY;
   // sweep owns the write port in INIT; rst discards any write or read in its cycle
   assign mwe = ~rst & (~ready | we);
   assign mre = ~rst & ready & re;
   sram_dp_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_core (
      .clk(clk),
      .we(mwe),
      .waddr(ready ? waddr : cnt),
      .wdata(ready ? wdata : '0),
      .wbe(ready ? wbe : '1),
      .re(mre),
      .raddr(raddr),
      .rdata(q)
   );
`ifdef SRAM_DP_BYPASS_EN
   logic hit;
   logic [WIDTH-1:0] wdata_q;
   logic [BW-1:0] wbe_q;
   always_ff @(posedge clk) begin
      hit <= mre & we & (waddr == raddr);
      wdata_q <= wdata;
      wbe_q <= wbe;
   end
   // array returned the pre-write word; overlay the bytes written in the same cycle
   always_comb begin
      rd = q;
      for (int i = 0; i < BW; i++) rd[i*8 +: 8] = (hit && wbe_q[i]) ? wdata_q[i*8 +: 8] : q[i*8 +: 8];
   end
`else
   assign rd = q;
`endif
   assign rdata = rvalid ? rd : hold;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt <= '0;
         rvalid <= 1'b0;
         init_done <= 1'b0;
         hold <= '0;
      end else begin
         rvalid <= mre;
         hold <= rdata;
         if (!ready) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
               state <= READY;
               init_done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_sram_dp_init.sv
// tb_sram_dp_init: directed scoreboard bench for sram_dp_init at default DEPTH=512, WIDTH=64
module tb_sram_dp_init;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic we = 1'b0;
   logic [8:0] waddr = '0;
   logic [63:0] wdata = '0;
   logic [7:0] wbe = '0;
   logic re = 1'b0;
   logic [8:0] raddr = '0;
   logic [63:0] rdata;
   logic rvalid, init_done;
   int n_chk = 0;
   int n_fail = 0;
   int run = 0;
   int max_run = 0;
   int cyc;
   logic [63:0] sb [$];
   logic [63:0] exp_v;
   logic [63:0] coll;
   logic [63:0] base = 64'h0F1E_2D3C_4B5A_6978;

   sram_dp_init dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .init_done(init_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         run++;
         if (run > max_run) max_run = run;
         n_chk++;
         assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL unexpected_rvalid observed rdata=%h, required no strobe", rdata);
         end
         if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_chk++;
            assert (rdata === exp_v) else begin
               n_fail++;
               $error("FAIL rdata observed=%h required=%h", rdata, exp_v);
            end
         end
      end else run = 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h required=%h", tag, obs, expv);
      end
   endtask

   task automatic wr(input logic [8:0] a, input logic [63:0] d, input logic [7:0] be);
      we = 1'b1; waddr = a; wdata = d; wbe = be;
      step();
      we = 1'b0;
   endtask

   task automatic rd(input logic [8:0] a, input logic [63:0] expv);
      re = 1'b1; raddr = a;
      sb.push_back(expv);
      step();
      re = 1'b0;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (init_done !== 1'b1 && n < 2000) begin
         step();
         n++;
      end
   endtask

   initial begin
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("reset_init_done", {63'd0, init_done}, 64'd0);
      chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      // requests during the sweep must be ignored
      we = 1'b1; waddr = 9'd3; wdata = '1; wbe = '1; re = 1'b1; raddr = 9'd3;
      wait_init(cyc);
      we = 1'b0; re = 1'b0;
      chk("sweep_cycles", 64'(cyc), 64'd512);
      rd(9'd0, 64'd0);
      rd(9'd255, 64'd0);
      rd(9'd511, 64'd0);
      rd(9'd3, 64'd0);
      wr(9'd5, 64'h0123_4567_89AB_CDEF, 8'hFF);
      rd(9'd5, 64'h0123_4567_89AB_CDEF);
      wr(9'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
      rd(9'd5, 64'h0123_4567_FFFF_FFFF);
      wr(9'd5, 64'h5555_5555_5555_5555, 8'h00);
      rd(9'd5, 64'h0123_4567_FFFF_FFFF);
      repeat (3) step();
      chk("hold_rdata", rdata, 64'h0123_4567_FFFF_FFFF);
      chk("hold_rvalid", {63'd0, rvalid}, 64'd0);
`ifdef SRAM_DP_BYPASS_EN
      coll = {8{8'hAA}};
`else
      coll = 64'd0;
`endif
      we = 1'b1; waddr = 9'd9; wdata = {8{8'hAA}}; wbe = 8'hFF;
      re = 1'b1; raddr = 9'd9;
      sb.push_back(coll);
      step();
      we = 1'b0; re = 1'b0;
      rd(9'd9, {8{8'hAA}});
      // independent ports: write 20 while reading 5
      we = 1'b1; waddr = 9'd20; wdata = 64'hDEAD_BEEF_0000_1111; wbe = 8'hFF;
      re = 1'b1; raddr = 9'd5;
      sb.push_back(64'h0123_4567_FFFF_FFFF);
      step();
      we = 1'b0; re = 1'b0;
      rd(9'd20, 64'hDEAD_BEEF_0000_1111);
      for (int i = 0; i < 8; i++) wr(9'(i), base ^ {8{8'(i)}}, 8'hFF);
      step();
      max_run = 0;
      for (int i = 0; i < 8; i++) begin
         re = 1'b1; raddr = 9'(i);
         sb.push_back(base ^ {8{8'(i)}});
         step();
      end
      re = 1'b0;
      step();
      chk("burst_run", 64'(max_run), 64'd8);
      // reset with a read and a write in the same cycle: both dropped
      re = 1'b1; raddr = 9'd5; we = 1'b1; waddr = 9'd6; wdata = '1; wbe = '1; rst = 1'b1;
      step();
      re = 1'b0; we = 1'b0; rst = 1'b0;
      chk("midrst_rvalid", {63'd0, rvalid}, 64'd0);
      chk("midrst_rdata", rdata, 64'd0);
      chk("midrst_init_done", {63'd0, init_done}, 64'd0);
      repeat (100) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      we = 1'b1; waddr = 9'd5; wdata = '1; wbe = '1;
      wait_init(cyc);
      we = 1'b0;
      chk("resweep_cycles", 64'(cyc), 64'd512);
      rd(9'd5, 64'd0);
      rd(9'd9, 64'd0);
      rd(9'd0, 64'd0);
      repeat (3) step();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sram_dp_init.md
SRAM_DP_INIT -- requirements
Module: sram_dp_init

Interface
REQ-001 SHALL have parameter DEPTH, default 512, number of words; power of two, >= 4.
REQ-002 SHALL have parameter WIDTH, default 64, bits per word; multiple of 8.
REQ-003 SHALL derive localparams AW = $clog2(DEPTH) and BW = WIDTH/8, not overridable.
REQ-004 SHALL have one clock, clk; reset rst is synchronous, active-high.
REQ-005 clk  input  1  single clock for all write, read and init logic.
REQ-006 rst  input  1  synchronous active-high reset; starts the clear sweep.
REQ-007 we  input  1  write request.
REQ-008 waddr  input  AW  write word address.
REQ-009 wdata  input  WIDTH  write data.
REQ-010 wbe  input  BW  byte write enables, active-high; bit i covers wdata[8i+7:8i].
REQ-011 re  input  1  read request.
REQ-012 raddr  input  AW  read word address.
REQ-013 rdata  output  WIDTH  read data.
REQ-014 rvalid  output  1  rdata valid strobe.
REQ-015 init_done  output  1  high once the clear sweep completes.

Function
REQ-016 SHALL implement FSM states INIT and READY; rst forces INIT.
REQ-017 In INIT, SHALL write all-zero words at addresses 0..DEPTH-1, one per cycle, ascending, using an AW-bit counter.
REQ-018 SHALL move INIT->READY in the cycle after the write to DEPTH-1; the sweep takes exactly DEPTH cycles.
REQ-019 init_done SHALL be 0 in INIT and 1 in READY.
REQ-020 we and re SHALL be ignored in INIT: no write, no rvalid.
REQ-021 In READY, we=1 SHALL update only the bytes of mem[waddr] whose wbe bit is set; wbe=0 SHALL leave the word unchanged.
REQ-022 In READY, re=1 SHALL give rvalid=1 and rdata=mem[raddr] in the next cycle (latency 1).
REQ-023 re may assert every cycle; full read throughput is required.
REQ-024 rvalid SHALL be a single-cycle strobe per accepted read.
REQ-025 rdata SHALL hold its last value while rvalid=0.
REQ-026 Writes and reads to different addresses in the same cycle SHALL be independent.
REQ-027 Same-address write and read in one cycle: behaviour is fixed by REQ-033/REQ-034.
REQ-028 rst asserted mid-operation SHALL restart the sweep at address 0, drop any read in flight (rvalid=0 next cycle) and discard the write in that cycle.

Reset
REQ-029 During rst, the following SHALL be forced: state=INIT, counter=0, rvalid=0, rdata=0, init_done=0.
REQ-030 Memory contents SHALL NOT be reset directly; zeroing is done only by the sweep.

Configuration
REQ-031 Macro SRAM_DP_BYPASS_EN SHALL control read-during-write forwarding.
REQ-032 SRAM_DP_BYPASS_EN SHALL affect only the same-address collision path.
REQ-033 With SRAM_DP_BYPASS_EN defined, on a same-address collision:
- the registered wdata/wbe SHALL be merged byte-wise over the array output;
- rdata SHALL equal the post-write word.
REQ-034 Without SRAM_DP_BYPASS_EN, on a same-address collision, rdata SHALL equal the pre-write word; no forwarding logic is compiled.

Structure
REQ-035 Package sram_pkg SHALL hold:
- SRAM_DEFAULT_DEPTH=512 and SRAM_DEFAULT_WIDTH=64;
- the FSM enum sram_init_state_t {INIT, READY}.
REQ-036 Sub-module sram_dp_core SHALL hold the raw 1W1R array with byte mask and 1-cycle registered read.
REQ-037 sram_dp_core is the single point for substituting a PDK dual-port macro.
REQ-038 The sweep FSM, rvalid tracking and bypass merge SHALL stay in sram_dp_init.

Verification
REQ-039 rst 1 cycle -> init_done=0 for exactly 512 cycles, then 1; reads at 0, 255 and 511 return 0.
REQ-040 Write addr 5, data 0x0123456789ABCDEF, wbe=0xFF; next cycle re addr 5 -> next cycle rvalid=1, rdata=0x0123456789ABCDEF.
REQ-041 Then write addr 5, data 0xFFFFFFFFFFFFFFFF, wbe=0x0F; read addr 5 -> rdata=0x01234567FFFFFFFF.
REQ-042 Same cycle: write addr 9 = 0xAA..AA (wbe=0xFF) and read addr 9, old value 0 -> rdata=0xAA..AA with SRAM_DP_BYPASS_EN, 0 without.
REQ-043 Back-to-back reads addr 0..7 -> rvalid high 8 consecutive cycles, data in address order.
REQ-044 rst mid-sweep at counter=100 -> sweep restarts at 0; init_done rises 512 cycles after rst deasserts; we during INIT leaves memory 0.
